// File: rtl/mbe_operand_driver_pkg.sv
// mbe_drv_pkg: shared FSM type, default width, corner-operand codes and LFSR taps
// for the MBE operand driver.
package mbe_drv_pkg;
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT_RES, CHECK, DONE} state_t;
    localparam int DEF_OP_W = 24;
    // Corner operands are width-independent codes; the driver decodes them for its OP_W.
    typedef enum logic [1:0] {C_ZERO, C_ONES, C_MSB, C_ONE} corner_t;
    localparam logic [3:0][1:0] CORNER_A = {C_ONES, C_MSB, C_ONES, C_ZERO};
    localparam logic [3:0][1:0] CORNER_B = {C_ONE, C_MSB, C_ONES, C_ZERO};
    // x^24 + x^23 + x^22 + x^17 + 1 in right-shifting Galois form.
    localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
endpackage

// File: rtl/mbe_operand_driver_if.sv
// mbe_operand_driver_if: operand and product handshakes between the driver (master)
// and the multiplier under test (slave).
interface mbe_operand_driver_if import mbe_drv_pkg::*; #(
    parameter int OP_W = DEF_OP_W
);
    logic [OP_W-1:0]   a_o;
    logic [OP_W-1:0]   b_o;
    logic              op_valid_o;
    logic              op_ready_i;
    logic [2*OP_W-1:0] res_data_i;
    logic              res_valid_i;
    logic              res_ready_o;
    modport master (
        output a_o, b_o, op_valid_o, res_ready_o,
        input  op_ready_i, res_data_i, res_valid_i
    );
    modport slave (
        input  a_o, b_o, op_valid_o, res_ready_o,
        output op_ready_i, res_data_i, res_valid_i
    );
endinterface

// File: rtl/mbe_operand_driver_lfsr.sv
// mbe_lfsr: right-shifting Galois LFSR with synchronous seed load; a zero seed is
// forced to 1 so the register can never lock up.
module mbe_lfsr import mbe_drv_pkg::*; #(
    parameter int               WIDTH = DEF_OP_W,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_24)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state
);
    logic [WIDTH-1:0] state_d, state_q;
    always_comb state_d = load ? (seed == '0 ? WIDTH'(1) : seed)
                        : en   ? ((state_q >> 1) ^ (state_q[0] ? TAPS : '0))
                        : state_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WIDTH'(1);
        else        state_q <= state_d;
    end
    assign state = state_q;
endmodule

// File: rtl/mbe_operand_driver.sv
// mbe_operand_driver: offers corner then LFSR operand pairs to a significand multiplier,
// one transaction in flight, and checks each product against a full-width reference.
module mbe_operand_driver import mbe_drv_pkg::*; #(
    parameter int OP_W    = DEF_OP_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [15:0]          num_ops,
    input  logic [OP_W-1:0]      seed,
    mbe_operand_driver_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [15:0]          pass_count,
    output logic [15:0]          err_count,
    output logic [15:0]          first_err_idx
);
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [15:0]     NO_ERR  = 16'hFFFF;

    state_t            state_d, state_q;
    logic [15:0]       idx_d, idx_q, n_d, n_q, pass_d, pass_q, err_d, err_q, first_d, first_q;
    logic [2*OP_W-1:0] exp_d, exp_q, res_d, res_q;
    logic [WD_W-1:0]   wd_d, wd_q;
    logic              timeout_d, timeout_q;
    logic [OP_W-1:0]   lfsr_a, lfsr_b, op_a, op_b;
    logic              launch, op_fire, res_fire;

    function automatic logic [OP_W-1:0] corner_val(input logic [1:0] c);
        return c == C_ZERO ? {OP_W{1'b0}}
             : c == C_ONES ? {OP_W{1'b1}}
             : c == C_MSB  ? {1'b1, {(OP_W-1){1'b0}}}
             : OP_W'(1);
    endfunction

    assign launch   = start && (state_q == IDLE || state_q == DONE);
    assign op_fire  = state_q == DRIVE && bus.op_ready_i;
    assign res_fire = state_q == WAIT_RES && bus.res_valid_i;
    assign op_a     = idx_q < 16'd4 ? corner_val(CORNER_A[idx_q[1:0]]) : lfsr_a;
    assign op_b     = idx_q < 16'd4 ? corner_val(CORNER_B[idx_q[1:0]]) : lfsr_b;

    mbe_lfsr #(.WIDTH(OP_W), .TAPS(OP_W'(LFSR_TAPS_24))) u_lfsr_a (
        .clk(clk), .rst_n(rst_n), .load(launch), .en(op_fire), .seed(seed), .state(lfsr_a)
    );
    mbe_lfsr #(.WIDTH(OP_W), .TAPS(OP_W'(LFSR_TAPS_24))) u_lfsr_b (
        .clk(clk), .rst_n(rst_n), .load(launch), .en(op_fire), .seed(~seed), .state(lfsr_b)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        pass_d    = pass_q;
        err_d     = err_q;
        first_d   = first_q;
        timeout_d = timeout_q;
        wd_d      = wd_q;
        exp_d     = op_fire ? (2*OP_W)'(op_a) * (2*OP_W)'(op_b) : exp_q;
        res_d     = res_fire ? bus.res_data_i : res_q;
        case (state_q)
            IDLE, DONE: if (launch) begin
                pass_d    = '0;
                err_d     = '0;
                first_d   = NO_ERR;
                timeout_d = 1'b0;
                idx_d     = '0;
                n_d       = num_ops;
                wd_d      = '0;
                state_d   = num_ops == '0 ? DONE : DRIVE;
            end
            // Watchdog counts consecutive stalled cycles; any handshake rearms it.
            DRIVE, WAIT_RES: if (op_fire || res_fire) begin
                wd_d    = '0;
                state_d = state_q == DRIVE ? WAIT_RES : CHECK;
            end else if (wd_q == WD_LAST) begin
                timeout_d = 1'b1;
                state_d   = DONE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
            CHECK: begin
                if (res_q == exp_q) begin
                    pass_d = pass_q + 16'(pass_q != 16'hFFFF);
                end else begin
                    err_d   = err_q + 16'(err_q != 16'hFFFF);
                    first_d = first_q == NO_ERR ? idx_q : first_q;
                end
                idx_d   = idx_q + 16'd1;
                state_d = idx_d == n_q ? DONE : DRIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            pass_q    <= '0;
            err_q     <= '0;
            first_q   <= NO_ERR;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            exp_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            first_q   <= first_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            exp_q     <= exp_d;
            res_q     <= res_d;
        end
    end

    assign bus.a_o         = state_q == DRIVE ? op_a : '0;
    assign bus.b_o         = state_q == DRIVE ? op_b : '0;
    assign bus.op_valid_o  = state_q == DRIVE;
    assign bus.res_ready_o = state_q == WAIT_RES;
    assign busy            = state_q == DRIVE || state_q == WAIT_RES || state_q == CHECK;
    assign done            = state_q == DONE;
    assign timeout         = timeout_q;
    assign pass_count      = pass_q;
    assign err_count       = err_q;
    assign first_err_idx   = first_q;
endmodule

// File: tb/tb_mbe_operand_driver.sv
// tb_mbe_operand_driver: scoreboard bench; runs queue the expected operand pairs and
// products, and a responder/monitor pops and checks them on every operand transfer.
module tb_mbe_operand_driver;
    localparam int OP_W = 24;

    typedef struct packed {
        logic [OP_W-1:0]   a;
        logic [OP_W-1:0]   b;
        logic [2*OP_W-1:0] p;
        logic              flip;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [15:0]       num_ops = '0;
    logic [OP_W-1:0]   seed = '0;
    logic              busy, done, timeout;
    logic [15:0]       pass_count, err_count, first_err_idx;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                opv_cnt = 0;
    int                rdy_mode = 0;
    bit                res_stall = 1'b0;
    bit                pend = 1'b0, op_fire = 1'b0, res_fire = 1'b0, hold_v = 1'b0;
    logic [OP_W-1:0]   hold_a, hold_b;
    logic [2*OP_W-1:0] prod;
    exp_t              e;
    exp_t              exp_q[$];

    mbe_operand_driver_if #(.OP_W(OP_W)) bus ();

    mbe_operand_driver #(.OP_W(OP_W), .TIMEOUT(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_ops(num_ops), .seed(seed), .bus(bus),
        .busy(busy), .done(done), .timeout(timeout), .pass_count(pass_count),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [OP_W-1:0] step(input logic [OP_W-1:0] s);
        return s[0] ? ((s >> 1) ^ 24'hE10000) : (s >> 1);
    endfunction

    // Responder + monitor: inputs change only on the falling edge, so a handshake seen
    // here is the one the DUT samples at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            op_fire = 1'b0;
            res_fire = 1'b0;
            hold_v = 1'b0;
            bus.op_ready_i = 1'b0;
            bus.res_valid_i = 1'b0;
        end else begin
            if (res_fire) pend = 1'b0;
            if (op_fire) pend = 1'b1;
            if (bus.op_valid_o) opv_cnt++;
            if (hold_v && bus.op_valid_o) begin
                chk("a_stable", 64'(bus.a_o), 64'(hold_a));
                chk("b_stable", 64'(bus.b_o), 64'(hold_b));
            end
            bus.op_ready_i = rdy_mode == 0 || (rdy_mode == 2 && $urandom_range(0, 2) != 0);
            bus.res_valid_i = pend && !(res_stall && $urandom_range(0, 2) == 0);
            op_fire = bus.op_valid_o && bus.op_ready_i;
            res_fire = bus.res_valid_i && bus.res_ready_o;
            hold_v = bus.op_valid_o && !bus.op_ready_i;
            hold_a = bus.a_o;
            hold_b = bus.b_o;
            if (op_fire) begin
                prod = (2*OP_W)'(bus.a_o) * (2*OP_W)'(bus.b_o);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL op_unexpected actual=%0h*%0h required=no transfer", bus.a_o, bus.b_o);
                    bus.res_data_i = prod;
                end else begin
                    e = exp_q.pop_front();
                    chk("op_a", 64'(bus.a_o), 64'(e.a));
                    chk("op_b", 64'(bus.b_o), 64'(e.b));
                    chk("product", 64'(prod), 64'(e.p));
                    bus.res_data_i = prod ^ (2*OP_W)'(e.flip);
                end
            end
        end
    end

    task automatic issue(input int n, input logic [OP_W-1:0] s, input int flip_idx);
        logic [OP_W-1:0]   ca [4] = '{24'h000000, 24'hFFFFFF, 24'h800000, 24'hFFFFFF};
        logic [OP_W-1:0]   cb [4] = '{24'h000000, 24'hFFFFFF, 24'h800000, 24'h000001};
        logic [2*OP_W-1:0] cp [4] = '{48'h0, 48'hFFFFFE000001, 48'h400000000000, 48'h000000FFFFFF};
        logic [OP_W-1:0]   la, lb;
        la = s == '0 ? OP_W'(1) : s;
        lb = (~s) == '0 ? OP_W'(1) : ~s;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            if (k < 4) exp_q.push_back('{ca[k], cb[k], cp[k], k == flip_idx});
            else exp_q.push_back('{la, lb, (2*OP_W)'(la) * (2*OP_W)'(lb), k == flip_idx});
            la = step(la);
            lb = step(lb);
        end
        @(negedge clk);
        num_ops = 16'(n);
        seed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        int c0;
        int v0;
        bit got;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_op_valid", 64'(bus.op_valid_o), 64'd0);
        chk("rst_res_ready", 64'(bus.res_ready_o), 64'd0);
        chk("rst_a", 64'(bus.a_o), 64'd0);
        chk("rst_busy_done_to", 64'({busy, done, timeout}), 64'd0);
        chk("rst_counts", 64'({pass_count, err_count}), 64'd0);
        chk("rst_first_err", 64'(first_err_idx), 64'hFFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = opv_cnt;
        repeat (3) @(negedge clk);
        chk("idle_no_op", 64'(opv_cnt - v0), 64'd0);
        chk("idle_done", 64'(done), 64'd0);

        // Empty run straight from IDLE.
        v0 = opv_cnt;
        issue(0, 24'h000000, -1);
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("empty_no_op", 64'(opv_cnt - v0), 64'd0);
        chk("empty_first_err", 64'(first_err_idx), 64'hFFFF);

        issue(4, 24'h000001, -1);
        wait_done(100, "corner");
        chk("corner_pass", 64'(pass_count), 64'd4);
        chk("corner_err", 64'(err_count), 64'd0);
        chk("corner_first_err", 64'(first_err_idx), 64'hFFFF);
        chk("corner_drained", 64'(exp_q.size()), 64'd0);

        issue(10, 24'h123456, 2);
        wait_done(300, "corrupt");
        chk("corrupt_pass", 64'(pass_count), 64'd9);
        chk("corrupt_err", 64'(err_count), 64'd1);
        chk("corrupt_first_err", 64'(first_err_idx), 64'd2);
        chk("corrupt_drained", 64'(exp_q.size()), 64'd0);

        rdy_mode = 1;
        issue(3, 24'h00C0DE, -1);
        chk("wd_op_valid", 64'(bus.op_valid_o), 64'd1);
        c0 = cyc;
        wait_done(2000, "wd");
        chk("wd_cycles", 64'(cyc - c0), 64'd1024);
        chk("wd_timeout", 64'(timeout), 64'd1);
        chk("wd_counts", 64'({pass_count, err_count}), 64'd0);
        chk("wd_outputs_low", 64'({bus.op_valid_o, bus.res_ready_o}), 64'd0);
        chk("wd_no_transfer", 64'(exp_q.size()), 64'd3);
        exp_q.delete();

        rdy_mode = 2;
        res_stall = 1'b1;
        issue(200, 24'h5A5A5A, -1);
        wait_done(8000, "bp");
        chk("bp_pass", 64'(pass_count), 64'd200);
        chk("bp_err", 64'(err_count), 64'd0);
        chk("bp_timeout", 64'(timeout), 64'd0);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        rdy_mode = 0;
        res_stall = 1'b0;

        // Asynchronous reset while a result is awaited, with counts already non-zero.
        issue(10, 24'h0F0F0F, -1);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = pass_count >= 16'd2 && bus.res_ready_o;
        end
        chk("rst_reached_wait_res", 64'(got), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_op_valid", 64'(bus.op_valid_o), 64'd0);
        chk("mid_rst_res_ready", 64'(bus.res_ready_o), 64'd0);
        chk("mid_rst_counts", 64'({pass_count, err_count}), 64'd0);
        chk("mid_rst_first_err", 64'(first_err_idx), 64'hFFFF);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = opv_cnt;
        repeat (4) @(negedge clk);
        chk("post_rst_no_op", 64'(opv_cnt - v0), 64'd0);
        chk("post_rst_idle", 64'({busy, done}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/mbe_operand_driver.md
MBE_OPERAND_DRIVER -- requirements
Module: mbe_operand_driver

Interface
REQ-001 Parameter OP_W, default 24: operand width of the significand multiplier under test.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles spent waiting on any single handshake.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a run; ignored unless the FSM is in IDLE or DONE.
REQ-006 num_ops  input  16  number of transactions in the run, sampled on start.
REQ-007 seed  input  OP_W  LFSR seed, sampled on start; a seed of 0 is replaced by 1.
REQ-008 a_o, b_o  output  OP_W each  operands driven to the multiplier.
REQ-009 op_valid_o  output  1  operand pair valid.
REQ-010 op_ready_i  input  1  multiplier accepts operands.
REQ-011 res_data_i  input  2*OP_W  product from the multiplier.
REQ-012 res_valid_i  input  1  product valid.
REQ-013 res_ready_o  output  1  driver accepts the product.
REQ-014 busy, done, timeout  output  1 each  run active; run finished; run aborted on watchdog.
REQ-015 pass_count, err_count  output  16 each  transaction checks passed and failed.
REQ-016 first_err_idx  output  16  index of the first failing transaction; 16'hFFFF if no failure.

Function
REQ-017 The FSM SHALL have five states: IDLE, DRIVE, WAIT_RES, CHECK and DONE.
REQ-018 IDLE/DONE + start SHALL: clear the counters and timeout, set first_err_idx to FFFF, and load the transaction index with 0; then go to DONE if num_ops==0, else to DRIVE.
REQ-019 In DRIVE, op_valid_o SHALL be 1, and a_o/b_o SHALL stay stable until op_valid_o and op_ready_i are both 1 in the same cycle.
REQ-020 On that transfer, the driver SHALL register expected = a_o*b_o at full 2*OP_W width, unsigned, with no truncation, and go to WAIT_RES.
REQ-021 In WAIT_RES, res_ready_o SHALL be 1 and op_valid_o SHALL be 0.
REQ-022 When res_valid_i and res_ready_o are both 1, the driver SHALL capture res_data_i and go to CHECK.
REQ-023 CHECK SHALL last one cycle and compare the captured result with expected, as follows:
- on equal, increment pass_count;
- otherwise, increment err_count and, if first_err_idx==FFFF, load it with the index;
- then increment the index.
REQ-024 CHECK SHALL then go to DONE if index==num_ops, else to DRIVE.
REQ-025 Result latency SHALL be fixed: the next op_valid_o rises 2 cycles after the result handshake cycle.
REQ-026 Transactions 0..3 SHALL use these corner operands:
- (0, 0);
- (2^OP_W-1, 2^OP_W-1);
- (2^(OP_W-1), 2^(OP_W-1));
- (2^OP_W-1, 1).
REQ-027 Later transactions SHALL take a_o and b_o from two OP_W-bit Galois LFSRs, seeded with seed and ~seed (zero replaced by 1), each advanced once per operand transfer.
REQ-028 At most one transaction SHALL be outstanding, so no new operands are offered before the previous result has been checked.
REQ-029 The watchdog SHALL count cycles in DRIVE or WAIT_RES without a handshake; when it reaches TIMEOUT, the driver SHALL set timeout, drop op_valid_o and res_ready_o, and go to DONE.
REQ-030 pass_count and err_count SHALL saturate at 16'hFFFF.
REQ-031 busy SHALL be 1 in DRIVE, WAIT_RES and CHECK.
REQ-032 done SHALL be 1 only in DONE and held there until the next start.
REQ-033 A result that arrives while not in WAIT_RES SHALL be left unaccepted, with res_ready_o=0.

Reset
REQ-034 While rst_n=0, immediately and independently of clk, the outputs SHALL be:
- state IDLE;
- a_o, b_o, op_valid_o, res_ready_o, busy, done and timeout all 0;
- pass_count and err_count 0;
- first_err_idx FFFF;
- LFSRs 1.
REQ-035 Reset asserted mid-run SHALL abandon the transaction in flight with no count update.
REQ-036 Release of rst_n SHALL be followed by IDLE, with no operand offered before start.

Structure
REQ-037 Package mbe_drv_pkg SHALL hold:
- the state enum typedef;
- the default OP_W;
- the corner-operand constants;
- the LFSR tap masks for OP_W=24 (x^24+x^23+x^22+x^17+1).
REQ-038 Sub-module mbe_lfsr SHALL have: parameter width, load/enable, seed input, state output; two instances.

Verification
REQ-039 The bench SHALL use OP_W=24 and cover the following scenarios:
- Reset: hold rst_n low mid-WAIT_RES -> op_valid_o=0, res_ready_o=0, counts 0 and first_err_idx=FFFF in the same cycle, without a clock edge.
- Corner run: ideal responder (always ready, correct product 1 cycle later), num_ops=4 -> products 0, 0xFFFFFE000001, 0x400000000000, 0xFFFFFF; then pass_count=4, err_count=0, done=1, first_err_idx=FFFF.
- Corrupted result: responder flips the product LSB on index 2 of a 10-transaction run -> err_count=1, pass_count=9, first_err_idx=2.
- Watchdog: op_ready_i held 0 after start, num_ops=3 -> timeout=1 and done=1 exactly 1024 cycles after op_valid_o rises; counts 0.
- Empty run: num_ops=0 -> done=1 one cycle after start, with no op_valid_o pulse.
- Backpressure: responder randomly stalls op_ready_i and res_valid_i, 200 operations, seed 0x5A5A5A -> a_o/b_o stable during every stall; pass_count=200, err_count=0.
